// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared types, constants and address-check helper for the AHB memory slave
package ahb_pkg;

    localparam int   DATA_W     = 32;
    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Offset is haddr minus the window base, so addresses below the base wrap high and fail too.
    function automatic logic addr_error(input logic [1:0]  byte_lane,
                                        input logic [31:0] offset,
                                        input logic [31:0] win_bytes);
        return (byte_lane != 2'b00) || (offset >= win_bytes);
    endfunction

endpackage

// File: rtl/ahb_mem_slave_if.sv
// rtl/ahb_mem_slave_if.sv - muxed AHB address/data bus seen by one memory slave slot
interface ahb_mem_slave_if;
    import ahb_pkg::*;

    logic              hsel;
    logic              hready;
    logic              hwrite;
    logic [31:0]       haddr;
    logic [DATA_W-1:0] hwdata;
    logic              hreadyout;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    modport master (
        output hsel, hready, hwrite, haddr, hwdata,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, hready, hwrite, haddr, hwdata,
        output hreadyout, hresp, hrdata
    );

endinterface

// File: rtl/ahb_mem_array.sv
// rtl/ahb_mem_array.sv - sync-write / registered-read word RAM with same-edge write forwarding
module ahb_mem_array
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_idx] <= wdata;
            end
            // A read landing on the word being written this edge must see the new data.
            if (rd_en) begin
                rdata <= (wr_en && (wr_idx == rd_idx)) ? wdata : mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/ahb_mem_slave.sv
// rtl/ahb_mem_slave.sv - AHB-style word memory slave with programmable wait states and error response
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int          ADDR_W      = 6,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic           hclk,
    input  logic           hresetn,
    ahb_mem_slave_if.slave bus
);

    localparam logic [31:0] WIN_BYTES = 32'd4 << ADDR_W;
    localparam logic [2:0]  WS_LOAD   = 3'(WAIT_STATES - 1);
    localparam bit          ZERO_WS   = (WAIT_STATES == 0);

    state_t            state;
    logic [2:0]        wait_cnt;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_idx;
    logic              ready_q;
    logic              resp_q;

    logic [31:0]       offset;
    logic              bad;
    logic              accept;
    logic              can_accept;
    logic              rd_now;
    logic              rd_late;
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] idx_in;
    logic [ADDR_W-1:0] rd_idx;

    assign offset     = bus.haddr - BASE_ADDR;
    assign bad        = addr_error(bus.haddr[1:0], offset, WIN_BYTES);
    assign idx_in     = offset[ADDR_W+1:2];
    assign accept     = bus.hsel && bus.hready;
    assign can_accept = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);

    // With no wait states the read is launched on the accept edge straight from haddr,
    // otherwise on the last wait edge from the latched index.
    assign rd_now  = ZERO_WS && can_accept && accept && !bad && !bus.hwrite;
    assign rd_late = (state == ST_WAIT) && (wait_cnt == 3'd0) && !lat_write;
    assign rd_en   = (rd_now || rd_late) && !hresetn;
    assign rd_idx  = rd_now ? idx_in : lat_idx;
    assign wr_en   = (state == ST_DONE) && lat_write && !hresetn;

    assign bus.hreadyout = ready_q;
    assign bus.hresp     = resp_q;

    ahb_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (hclk),
        .rst    (hresetn),
        .wr_en  (wr_en),
        .wr_idx (lat_idx),
        .wdata  (bus.hwdata),
        .rd_en  (rd_en),
        .rd_idx (rd_idx),
        .rdata  (bus.hrdata)
    );

    always_ff @(posedge hclk) begin
        if (hresetn) begin
            state     <= ST_IDLE;
            wait_cnt  <= 3'd0;
            lat_write <= 1'b0;
            lat_idx   <= '0;
            ready_q   <= 1'b1;
            resp_q    <= RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    if (accept) begin
                        lat_write <= bus.hwrite;
                        lat_idx   <= idx_in;
                        if (bad) begin
                            state   <= ST_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= RESP_ERROR;
                        end else if (ZERO_WS) begin
                            state   <= ST_DONE;
                            ready_q <= 1'b1;
                            resp_q  <= RESP_OKAY;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WS_LOAD;
                            ready_q  <= 1'b0;
                            resp_q   <= RESP_OKAY;
                        end
                    end else begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= RESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state   <= ST_DONE;
                        ready_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state   <= ST_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= RESP_ERROR;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    resp_q  <= RESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb/tb_ahb_mem_slave.sv - scoreboard bench over four slave slots with different wait states and bases
module tb_ahb_mem_slave;

    typedef struct packed {
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
    } tr_t;

    typedef struct packed {
        logic        w;
        logic        err;
        logic [31:0] data;
        logic [3:0]  low;
    } exp_t;

    logic        clk;
    logic        rst_a    [4];
    logic        hsel_a   [4];
    logic        hwrite_a [4];
    logic [31:0] haddr_a  [4];
    logic [31:0] hwdata_a [4];
    logic [3:0]  hready_o;
    logic [3:0]  hresp_o;
    logic [31:0] hrdata_o [4];

    tr_t         tr_q [$];
    exp_t        sb   [$];
    logic [31:0] model_mem [4][64];
    logic [31:0] last_rd   [4];
    int          total;
    int          bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int          WS   = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 7;
        localparam logic [31:0] BASE = (g == 3) ? 32'h0000_1000 : 32'h0000_0000;

        ahb_mem_slave_if bus ();

        assign bus.hsel    = hsel_a[g];
        assign bus.hwrite  = hwrite_a[g];
        assign bus.haddr   = haddr_a[g];
        assign bus.hwdata  = hwdata_a[g];
        assign bus.hready  = bus.hreadyout;
        assign hready_o[g] = bus.hreadyout;
        assign hresp_o[g]  = bus.hresp;
        assign hrdata_o[g] = bus.hrdata;

        ahb_mem_slave #(
            .ADDR_W      (6),
            .WAIT_STATES (WS),
            .BASE_ADDR   (BASE)
        ) dut (
            .hclk    (clk),
            .hresetn (rst_a[g]),
            .bus     (bus.slave)
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 3 : 7;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 3) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic add(input int d, input logic w, input logic [31:0] off, input logic [31:0] data);
        tr_t t;
        t.w    = w;
        t.addr = base_of(d) + off;
        t.data = data;
        tr_q.push_back(t);
    endtask

    task automatic drive(input int d, input bit ha, input tr_t a, input bit hd, input tr_t p);
        hsel_a[d]   = ha;
        hwrite_a[d] = ha ? a.w : 1'b0;
        haddr_a[d]  = ha ? a.addr : 32'h0;
        hwdata_a[d] = (hd && p.w) ? p.data : 32'hBAD0_BAD0;
    endtask

    task automatic push_expect(input int d, input tr_t t);
        exp_t        e;
        logic [31:0] off;
        off    = t.addr - base_of(d);
        e.w    = t.w;
        e.err  = (t.addr[1:0] != 2'b00) || (off >= 32'h100);
        e.low  = e.err ? 4'd1 : 4'(ws_of(d));
        e.data = 32'h0;
        if (!e.err) begin
            if (t.w) model_mem[d][off[7:2]] = t.data;
            else     e.data = model_mem[d][off[7:2]];
        end
        sb.push_back(e);
    endtask

    task automatic run(input int d);
        tr_t  cur_a;
        tr_t  cur_dp;
        bit   have_a;
        bit   have_dp;
        int   lows;
        int   cyc;
        exp_t e;
        have_dp = 0;
        lows    = 0;
        cyc     = 0;
        cur_dp  = '0;
        cur_a   = '0;
        have_a  = (tr_q.size() > 0);
        if (have_a) cur_a = tr_q.pop_front();
        @(posedge clk); #1;
        drive(d, have_a, cur_a, have_dp, cur_dp);
        while ((have_a || have_dp) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (have_dp) begin
                e = sb[0];
                if (!hready_o[d]) begin
                    lows++;
                    check_eq("wait_resp", 32'(hresp_o[d]), 32'(e.err));
                    check_eq("wait_hold", hrdata_o[d], last_rd[d]);
                end else begin
                    e = sb.pop_front();
                    check_eq("low_cycles", lows, 32'(e.low));
                    check_eq("resp", 32'(hresp_o[d]), 32'(e.err));
                    if (!e.w && !e.err) last_rd[d] = e.data;
                    check_eq("rdata", hrdata_o[d], last_rd[d]);
                    have_dp = 0;
                end
            end else begin
                check_eq("idle_ready", 32'(hready_o[d]), 32'd1);
            end
            if (hready_o[d] && have_a) begin
                push_expect(d, cur_a);
                cur_dp  = cur_a;
                have_dp = 1;
                lows    = 0;
                have_a  = (tr_q.size() > 0);
                if (have_a) cur_a = tr_q.pop_front();
            end
            @(posedge clk); #1;
            drive(d, have_a, cur_a, have_dp, cur_dp);
        end
        check_eq("drained", 32'(have_a || have_dp), 32'd0);
        tr_q.delete();
        sb.delete();
    endtask

    task automatic idle_test(input int d);
        hsel_a[d]   = 1'b0;
        hwrite_a[d] = 1'b1;
        haddr_a[d]  = base_of(d) + 32'h08;
        hwdata_a[d] = 32'hFFFF_FFFF;
        repeat (5) begin
            @(negedge clk);
            check_eq("idle5_ready", 32'(hready_o[d]), 32'd1);
            check_eq("idle5_resp", 32'(hresp_o[d]), 32'd0);
        end
        add(d, 1'b0, 32'h08, 32'h0);
        run(d);
    endtask

    task automatic reset_mid(input int d);
        @(posedge clk); #1;
        hsel_a[d]   = 1'b1;
        hwrite_a[d] = 1'b1;
        haddr_a[d]  = base_of(d) + 32'h0C;
        hwdata_a[d] = 32'h0;
        @(negedge clk);
        check_eq("rm_idle", 32'(hready_o[d]), 32'd1);
        @(posedge clk); #1;
        hsel_a[d]   = 1'b0;
        hwrite_a[d] = 1'b0;
        hwdata_a[d] = 32'h55;
        @(negedge clk);
        check_eq("rm_wait", 32'(hready_o[d]), 32'd0);
        rst_a[d] = 1'b1;
        @(posedge clk); #1;
        rst_a[d] = 1'b0;
        @(negedge clk);
        check_eq("rm_ready", 32'(hready_o[d]), 32'd1);
        check_eq("rm_resp", 32'(hresp_o[d]), 32'd0);
        for (int i = 0; i < 64; i++) model_mem[d][i] = 32'h0;
        last_rd[d] = 32'h0;
        add(d, 1'b0, 32'h0C, 32'h0);
        add(d, 1'b0, 32'h08, 32'h0);
        run(d);
    endtask

    task automatic gen_random(input int d, input int n);
        int          r;
        logic [31:0] off;
        for (int i = 0; i < n; i++) begin
            r   = $urandom_range(0, 7);
            off = 32'($urandom_range(0, 7)) * 4;
            if (r == 6)      off = off + 32'd2;
            else if (r == 7) off = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC : 32'h100 + off;
            add(d, 1'($urandom_range(0, 1)), off, $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int d = 0; d < 4; d++) begin
            rst_a[d]    = 1'b1;
            hsel_a[d]   = 1'b0;
            hwrite_a[d] = 1'b0;
            haddr_a[d]  = 32'h0;
            hwdata_a[d] = 32'h0;
            last_rd[d]  = 32'h0;
            for (int i = 0; i < 64; i++) model_mem[d][i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) rst_a[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check_eq("rst_ready", 32'(hready_o[d]), 32'd1);
            check_eq("rst_resp", 32'(hresp_o[d]), 32'd0);
            check_eq("rst_rdata", hrdata_o[d], 32'd0);
        end

        add(0, 1'b1, 32'h08, 32'hDEAD_BEEF);
        run(0);
        add(0, 1'b0, 32'h08, 32'h0);
        run(0);

        for (int d = 0; d < 2; d++) begin
            add(d, 1'b1, 32'h00, 32'h0000_A5A5 + 32'(d));
            add(d, 1'b0, 32'h02, 32'h0);
            add(d, 1'b0, 32'h100, 32'h0);
            add(d, 1'b0, 32'h00, 32'h0);
            run(d);
        end

        add(1, 1'b1, 32'h00, 32'h11);
        add(1, 1'b1, 32'h04, 32'h22);
        add(1, 1'b0, 32'h04, 32'h0);
        add(1, 1'b0, 32'h00, 32'h0);
        run(1);

        for (int d = 1; d < 4; d++) begin
            add(d, 1'b1, 32'h10, 32'hC0DE_0000 + 32'(d));
            run(d);
            add(d, 1'b0, 32'h10, 32'h0);
            run(d);
        end

        idle_test(0);
        reset_mid(0);

        for (int d = 0; d < 4; d++) begin
            gen_random(d, 16);
            run(d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
